// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with a first-word-fall-through receive FIFO. The serial line
//   is synchronised and sampled mid-bit. Frames carry DATA_BITS data bits (LSB
//   first), optional odd/even parity and STOP_BITS stop bits. Good words are
//   queued. Framing, parity and overflow errors are reported as one-cycle pulses.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   data_out    FIFO head word; holds its last value while the FIFO is empty
//   valid       FIFO not empty
//   ready       consumer accepts the head word; a pop happens on valid && ready
//   count       FIFO occupancy
//   frame_err   one-cycle pulse: a stop bit was sampled low (word discarded)
//   parity_err  one-cycle pulse: parity mismatch (word discarded)
//   overflow    one-cycle pulse: a good word was dropped because the FIFO was full
//   busy        receiver active, from start detection through frame completion
//
// Receiver states
//   state    | meaning
//   S_IDLE   | line idle, waiting for a low level on rx_s
//   S_START  | half-bit wait, then confirm the start bit or reject a glitch
//   S_DATA   | sample DATA_BITS data bits at mid-bit, LSB first
//   S_PARITY | sample the parity bit (only when PARITY != 0)
//   S_STOP   | sample STOP_BITS stop bits; the last sample ends the frame

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx,
  output logic [DATA_BITS-1:0]              data_out,
  output logic                              valid,
  input  logic                              ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overflow,
  output logic                              busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT/2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_bad;
  logic                 par_fail;
  logic                 word_ok;
  logic                 done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    par_fail = 1'b0;
    if (PARITY == 1)
      par_fail = ~(^shreg ^ par_bit);
    else if (PARITY == 2)
      par_fail = ^shreg ^ par_bit;
  end

  // Completion results are registered, so pulses and the push request appear
  // in the cycle after the last stop sample. shreg is left untouched in IDLE
  // and START, so it still holds the word during that cycle even if a new
  // start edge is seen immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_bad   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      word_ok    <= 1'b0;
      done       <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      word_ok    <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            timer    <= T_HALF;
            bit_cnt  <= '0;
            stop_bad <= 1'b0;
          end
        end
        S_START: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (rx_s) begin
            state <= S_IDLE;
          end else begin
            state <= S_DATA;
            timer <= T_FULL;
          end
        end
        S_DATA: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            timer <= T_FULL;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            par_bit <= rx_s;
            timer   <= T_FULL;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            timer <= T_FULL;
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state      <= S_IDLE;
              done       <= 1'b1;
              frame_err  <= stop_bad | ~rx_s;
              parity_err <= ~(stop_bad | ~rx_s) & par_fail;
              word_ok    <= ~(stop_bad | ~rx_s) & ~par_fail;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              if (!rx_s)
                stop_bad <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE) | done;

  // Receive FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic                 full, pop, push;

  assign valid    = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = valid & ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push     = word_ok & (~full | pop);
  assign overflow = word_ok & full & ~pop;

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= shreg;
  end

  // data_out is a register tracking the head. On a pop it takes the next
  // stored entry, or the incoming word when that is the only one left.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        if (count > CW'(1))
          data_out <= mem[rptr + AW'(1)];
        else if (push)
          data_out <= shreg;
      end else if (!valid && push) begin
        data_out <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_v[3];
  logic       ready_v[3];
  logic [7:0] dout_a, dout_b;
  logic [6:0] dout_c;
  logic [2:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       vld[3], fe[3], pe[3], ov[3], bsy[3];
  logic [8:0] dout[3];
  int         cnt[3];

  assign dout[0] = {1'b0, dout_a};
  assign dout[1] = {1'b0, dout_b};
  assign dout[2] = {2'b00, dout_c};
  assign cnt[0]  = 32'(cnt_a);
  assign cnt[1]  = 32'(cnt_b);
  assign cnt[2]  = 32'(cnt_c);

  // dut 0: 8N1, depth 4; dut 1: 8 bits even parity, 2 stop, depth 4;
  // dut 2: 7 bits odd parity, 1 stop, 8 clocks per bit, depth 2
  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .data_out(dout_a), .valid(vld[0]), .ready(ready_v[0]),
    .count(cnt_a), .frame_err(fe[0]), .parity_err(pe[0]), .overflow(ov[0]), .busy(bsy[0]));
  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .data_out(dout_b), .valid(vld[1]), .ready(ready_v[1]),
    .count(cnt_b), .frame_err(fe[1]), .parity_err(pe[1]), .overflow(ov[1]), .busy(bsy[1]));
  uart_rx_fifo #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .data_out(dout_c), .valid(vld[2]), .ready(ready_v[2]),
    .count(cnt_c), .frame_err(fe[2]), .parity_err(pe[2]), .overflow(ov[2]), .busy(bsy[2]));

  int cpb[3]   = '{16, 16, 8};
  int dbits[3] = '{8, 8, 7};
  int par[3]   = '{0, 2, 1};
  int stopn[3] = '{1, 2, 1};
  int depth[3] = '{4, 4, 2};

  int tests = 0;
  int fails = 0;

  // observed pulse counts
  int fe_n[3] = '{0, 0, 0};
  int pe_n[3] = '{0, 0, 0};
  int ov_n[3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fe[i] === 1'b1) fe_n[i]++;
      if (pe[i] === 1'b1) pe_n[i]++;
      if (ov[i] === 1'b1) ov_n[i]++;
    end
  end

  // reference model: FIFO contents and expected pulse counts
  logic [8:0] mq[3][16];
  int mcnt[3]   = '{0, 0, 0};
  int exp_fe[3] = '{0, 0, 0};
  int exp_pe[3] = '{0, 0, 0};
  int exp_ov[3] = '{0, 0, 0};
  int lat;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] msk(int s, logic [8:0] d);
    return d & 9'((1 << dbits[s]) - 1);
  endfunction

  function automatic logic good_par(int s, logic [8:0] d);
    logic x;
    x = ^msk(s, d);
    return (par[s] == 1) ? ~x : x;
  endfunction

  task automatic mpop(int s);
    for (int i = 0; i < 15; i++) mq[s][i] = mq[s][i+1];
    mcnt[s]--;
  endtask

  // expected outcome of one frame, assuming no pop during its completion
  task automatic model_frame(int s, logic [8:0] d, logic p, logic [1:0] stops);
    logic stop_ok, par_ok;
    stop_ok = stops[0] && (stopn[s] == 1 || stops[1]);
    par_ok  = (par[s] == 0) || (p == good_par(s, d));
    if (!stop_ok) exp_fe[s]++;
    else if (!par_ok) exp_pe[s]++;
    else if (mcnt[s] < depth[s]) begin
      mq[s][mcnt[s]] = msk(s, d);
      mcnt[s]++;
    end else exp_ov[s]++;
  endtask

  // drives one frame starting at the current negedge; abort_bits>0 stops early
  task automatic send(int s, logic [8:0] d, logic p, logic [1:0] stops, int abort_bits);
    logic b[16];
    int n;
    b[0] = 1'b0;
    n = 1;
    for (int i = 0; i < dbits[s]; i++) begin b[n] = d[i]; n++; end
    if (par[s] != 0) begin b[n] = p; n++; end
    for (int i = 0; i < stopn[s]; i++) begin b[n] = stops[i]; n++; end
    for (int i = 0; i < n; i++) begin
      if (abort_bits != 0 && i == abort_bits) break;
      rx_v[s] = b[i];
      repeat (cpb[s]) @(negedge clk);
    end
    rx_v[s] = 1'b1;
  endtask

  task automatic frame(int s, logic [8:0] d, logic p, logic [1:0] stops);
    send(s, d, p, stops, 0);
    model_frame(s, d, p, stops);
    repeat (2 * cpb[s]) @(negedge clk);
  endtask

  task automatic check_state(int s, string tag);
    check({tag, "_count"}, cnt[s], mcnt[s]);
    check({tag, "_frame_err_pulses"}, fe_n[s], exp_fe[s]);
    check({tag, "_parity_err_pulses"}, pe_n[s], exp_pe[s]);
    check({tag, "_overflow_pulses"}, ov_n[s], exp_ov[s]);
  endtask

  task automatic drain(int s, string tag);
    ready_v[s] = 1'b1;
    while (mcnt[s] > 0) begin
      check({tag, "_valid"}, 32'(vld[s]), 1);
      check({tag, "_data"}, 32'(dout[s]), 32'(mq[s][0]));
      mpop(s);
      @(negedge clk);
    end
    check({tag, "_empty"}, 32'(vld[s]), 0);
    ready_v[s] = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    logic [1:0] st;
    logic       p;
    int         e, k;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin rx_v[i] = 1'b1; ready_v[i] = 1'b0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_count", cnt[i], 0);
      check("rst_valid", 32'(vld[i]), 0);
      check("rst_data", 32'(dout[i]), 0);
      check("rst_busy", 32'(bsy[i]), 0);
      check("rst_pulses", 32'({fe[i], pe[i], ov[i]}), 0);
    end
    @(negedge clk);

    // back-to-back frames, held then drained; first frame also measures latency
    lat = 0;
    fork
      send(0, 9'h00, 1'b0, 2'b11, 0);
      begin
        while (vld[0] !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
      end
    join
    model_frame(0, 9'h00, 1'b0, 2'b11);
    send(0, 9'h01, 1'b0, 2'b11, 0); model_frame(0, 9'h01, 1'b0, 2'b11);
    send(0, 9'h02, 1'b0, 2'b11, 0); model_frame(0, 9'h02, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    check_state(0, "t1");
    check("t1_latency_in_range", 32'(lat >= 148 && lat <= 164), 1);
    drain(0, "t1_drain");

    // false start
    rx_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("t2_busy_during", 32'(bsy[0]), 1);
    rx_v[0] = 1'b1;
    k = 0;
    while (bsy[0] !== 1'b0 && k < 12) begin @(negedge clk); k++; end
    check("t2_busy_release", 32'(k <= cpb[0]/2 + 3), 1);
    repeat (40) @(negedge clk);
    check_state(0, "t2");

    // even parity
    frame(1, 9'hA5, 1'b1, 2'b11);
    check_state(1, "t3_bad_parity");
    frame(1, 9'hA5, 1'b0, 2'b11);
    check_state(1, "t3_good");
    drain(1, "t3_drain");

    // second stop bit low; then frame error masking a parity error
    frame(1, 9'h3C, 1'b0, 2'b01);
    check_state(1, "t4_stop2_low");
    frame(1, 9'h3C, 1'b1, 2'b10);
    check_state(1, "t4_precedence");

    // overflow, then full with simultaneous pop
    for (int i = 0; i < 5; i++) frame(0, 9'(8'h10 + i), 1'b0, 2'b11);
    check_state(0, "t5_overflow");
    drain(0, "t5_drain");
    for (int i = 0; i < 4; i++) begin
      send(0, 9'(8'h10 + i), 1'b0, 2'b11, 0);
      model_frame(0, 9'(8'h10 + i), 1'b0, 2'b11);
    end
    repeat (4) @(negedge clk);
    fork
      send(0, 9'h14, 1'b0, 2'b11, 0);
      begin
        repeat (lat - 1) @(negedge clk);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
      end
    join
    mpop(0);
    mq[0][mcnt[0]] = 9'h14;
    mcnt[0]++;
    repeat (4) @(negedge clk);
    check_state(0, "t5_push_pop_full");
    drain(0, "t5_drain2");

    // reset in the middle of a frame
    frame(0, 9'h77, 1'b0, 2'b11);
    send(0, 9'h55, 1'b0, 2'b11, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    check("t6_count", cnt[0], 0);
    check("t6_busy", 32'(bsy[0]), 0);
    check("t6_count_b", cnt[1], 0);
    repeat (3 * cpb[0]) @(negedge clk);
    frame(0, 9'h66, 1'b0, 2'b11);
    check_state(0, "t6_after");
    drain(0, "t6_drain");

    // randomized frames on every configuration
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 3; r++) begin
        for (int f = 0; f < depth[s] + 1; f++) begin
          d  = 9'($urandom);
          e  = int'($urandom_range(0, 3));
          p  = good_par(s, d);
          st = 2'b11;
          if (e == 0 && par[s] != 0) p = ~p;
          if (e == 1) st = (stopn[s] == 2) ? 2'($urandom_range(0, 2)) : 2'b10;
          frame(s, d, p, st);
        end
        check_state(s, "rand");
        drain(s, "rand_drain");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
